// File: rtl/pls_gen.sv
// rtl/pls_gen.sv - pulse and clear tick source for the watch pulse-counter chain
//
// Generates the counter chain's pulse (plso) and clear (clro) from clk under
// start/stop/clear controls. Outputs are sequenced so that clro never rises
// before a falling plso edge it caused has been counted.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   async level, rising edge requests run/resume
//   stop     in   async level, rising edge requests pause
//   clr_req  in   async level, rising edge requests clear
//   plso     out  pulse train, counters advance on its falling edge
//   clro     out  clear pulse, counters clear on its rising edge
//   run      out  high while in RUN
//   pls_cnt  out  plso falling edges since last clear, wraps at 16 bits

module pls_gen #(
  parameter int DIV      = 100,
  parameter int HIGH_CYC = 50,
  parameter int CLR_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clr_req,
  output logic        plso,
  output logic        clro,
  output logic        run,
  output logic [15:0] pls_cnt
);

  localparam int DW = $clog2(DIV);
  localparam int SW = $clog2(CLR_CYC + 2) + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] HIGH_LIM  = DW'(HIGH_CYC);
  localparam logic [SW-1:0] CLR_FIRST = SW'(2);
  localparam logic [SW-1:0] CLR_LAST  = SW'(CLR_CYC + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  // Bit order in the conditioning chain: {clr_req, stop, start}
  logic [2:0] in_s1;
  logic [2:0] in_s2;
  logic [2:0] in_hist;
  logic [2:0] in_edge;
  logic       start_edge;
  logic       stop_edge;
  logic       clr_edge;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [DW-1:0] div;
  logic [DW-1:0] div_n;
  logic [DW-1:0] div_adv;
  logic [SW-1:0] sub;
  logic [SW-1:0] sub_n;
  logic [SW-1:0] sub_inc;
  logic          plso_n;
  logic          clro_n;
  logic          cnt_zero;
  logic          plso_fall;

  // Two-flop synchronizer plus history flop; edges last exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_s1   <= 3'b000;
      in_s2   <= 3'b000;
      in_hist <= 3'b000;
    end else begin
      in_s1   <= {clr_req, stop, start};
      in_s2   <= in_s1;
      in_hist <= in_s2;
    end
  end

  assign in_edge    = in_s2 & ~in_hist;
  assign start_edge = in_edge[0];
  assign stop_edge  = in_edge[1];
  assign clr_edge   = in_edge[2];

  assign div_adv = (div == DIV_LAST) ? '0 : div + 1'b1;
  assign sub_inc = sub + 1'b1;

  always_comb begin
    state_n  = state;
    div_n    = div;
    plso_n   = plso;
    clro_n   = clro;
    sub_n    = sub;
    cnt_zero = 1'b0;

    case (state)
      ST_IDLE: begin
        div_n  = '0;
        plso_n = 1'b0;
        clro_n = 1'b0;
        if (clr_edge) begin
          state_n = ST_CLEAR;
          sub_n   = '0;
        end else if (start_edge) begin
          // Any stop edge in the same cycle is ignored here.
          state_n = ST_RUN;
          plso_n  = 1'b1;
        end
      end

      ST_RUN: begin
        if (clr_edge) begin
          state_n = ST_CLEAR;
          sub_n   = '0;
          div_n   = '0;
          plso_n  = 1'b0;
          clro_n  = 1'b0;
        end else if (stop_edge) begin
          // Freeze div and plso as they stand; a paused high phase stays
          // high so the chain sees no falling edge.
          state_n = ST_PAUSE;
        end else begin
          div_n  = div_adv;
          plso_n = (div_adv < HIGH_LIM);
        end
      end

      ST_PAUSE: begin
        if (clr_edge) begin
          state_n = ST_CLEAR;
          sub_n   = '0;
          div_n   = '0;
          plso_n  = 1'b0;
          clro_n  = 1'b0;
        end else if (start_edge) begin
          // Resume advances from the frozen position on this same edge.
          state_n = ST_RUN;
          div_n   = div_adv;
          plso_n  = (div_adv < HIGH_LIM);
        end
      end

      ST_CLEAR: begin
        // All control edges are discarded while clearing.
        plso_n = 1'b0;
        div_n  = '0;
        if (sub == CLR_LAST) begin
          state_n = ST_IDLE;
          sub_n   = '0;
          clro_n  = 1'b0;
        end else begin
          sub_n = sub_inc;
          // clro lags the plso drop by two cycles so that drop is counted
          // downstream before the clear lands.
          clro_n   = (sub_inc >= CLR_FIRST) && (sub_inc <= CLR_LAST);
          cnt_zero = (sub_inc == CLR_FIRST);
        end
      end

      default: begin
        state_n = ST_IDLE;
        div_n   = '0;
        plso_n  = 1'b0;
        clro_n  = 1'b0;
        sub_n   = '0;
      end
    endcase
  end

  assign plso_fall = plso & ~plso_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div     <= '0;
      sub     <= '0;
      plso    <= 1'b0;
      clro    <= 1'b0;
      run     <= 1'b0;
      pls_cnt <= 16'h0000;
    end else begin
      state <= state_n;
      div   <= div_n;
      sub   <= sub_n;
      plso  <= plso_n;
      clro  <= clro_n;
      run   <= (state_n == ST_RUN);
      // The CLEAR-entry drop is counted first; zeroing happens with clro rise.
      if (cnt_zero) begin
        pls_cnt <= 16'h0000;
      end else if (plso_fall) begin
        pls_cnt <= pls_cnt + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_pls_gen.sv
// tb/tb_pls_gen.sv - scoreboard testbench for pls_gen

module tb_pls_gen;

    localparam int K_PLSO = 0;
    localparam int K_CLRO = 1;
    localparam int K_RUN  = 2;
    localparam int K_CNT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        clr_req;
    logic        plso;
    logic        clro;
    logic        run;
    logic [15:0] pls_cnt;

    always #5 clk = ~clk;

    pls_gen #(
        .DIV      (10),
        .HIGH_CYC (3),
        .CLR_CYC  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .clr_req (clr_req),
        .plso    (plso),
        .clro    (clro),
        .run     (run),
        .pls_cnt (pls_cnt)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [15:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_PLSO:  act = {15'd0, plso};
                    K_CLRO:  act = {15'd0, clro};
                    K_RUN:   act = {15'd0, run};
                    default: act = pls_cnt;
                endcase
                checks++;
                if (act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h", sb[i].nm, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expv(input int c, input int k, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    initial begin
        int b, t, r, c, s, q;
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        clr_req = 1'b0;

        step(3);
        expv(cyc, K_PLSO, 0, "rst_plso");
        expv(cyc, K_CLRO, 0, "rst_clro");
        expv(cyc, K_RUN,  0, "rst_run");
        expv(cyc, K_CNT,  0, "rst_cnt");
        checks++;
        if (plso !== 1'b0 || clro !== 1'b0 || run !== 1'b0 || pls_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL rst_direct cyc=%0d plso=%b clro=%b run=%b cnt=%h", cyc, plso, clro, run, pls_cnt);
        end
        rst = 1'b0;

        step(2);
        start = 1'b1;
        b = cyc + 3;
        expv(b - 1, K_RUN,  0, "s1_run_pre");
        expv(b - 1, K_PLSO, 0, "s1_plso_pre");
        expv(b,     K_RUN,  1, "s1_run");
        for (int k = 0; k < 50; k++) expv(b + k, K_PLSO, 16'((k % 10) < 3), "s1_plso_pattern");
        expv(b + 2,  K_CNT, 0, "s1_cnt_before_fall");
        expv(b + 3,  K_CNT, 1, "s1_cnt_first_fall");
        expv(b + 49, K_CNT, 5, "s1_cnt_5_periods");
        step(5);
        start = 1'b0;

        step((b + 59) - cyc);
        stop = 1'b1;
        t = b + 62;
        expv(t - 1, K_PLSO, 1, "s2_plso_pre");
        expv(t,     K_RUN,  0, "s2_run_paused");
        for (int j = 0; j < 50; j++) begin
            expv(t + j, K_PLSO, 1, "s2_hold_plso");
            expv(t + j, K_CNT,  6, "s2_hold_cnt");
        end
        step(5);
        stop = 1'b0;

        step((t + 47) - cyc);
        start = 1'b1;
        r = t + 50;
        expv(r, K_RUN, 1, "s2_run_resume");
        expv(r, K_CNT, 6, "s2_cnt_resume");
        for (int j = 0; j <= 8; j++) expv(r + j, K_PLSO, 16'(((2 + j) % 10) < 3), "s2_resume_plso");
        expv(r + 1, K_CNT, 7, "s2_cnt_after_resume");
        expv(r + 8, K_CNT, 7, "s2_cnt_next_high");

        step((r + 6) - cyc);
        stop    = 1'b1;
        clr_req = 1'b1;
        start   = 1'b0;
        c = r + 9;
        expv(c,     K_CNT,  8, "s3_entry_cnt");
        expv(c,     K_RUN,  0, "s3_entry_run");
        expv(c,     K_CLRO, 0, "s3_entry_clro");
        expv(c + 1, K_CLRO, 0, "s3_clro_lag");
        expv(c + 1, K_CNT,  8, "s3_cnt_held");
        expv(c + 2, K_CNT,  0, "s3_cnt_zeroed");
        for (int j = 0; j < 6; j++) expv(c + j, K_PLSO, 0, "s3_plso_low");
        for (int j = 2; j <= 5; j++) expv(c + j, K_CLRO, 1, "s3_clro_high");
        expv(c + 6, K_CLRO, 0, "s3_clro_end");
        for (int j = 6; j <= 14; j++) begin
            expv(c + j, K_RUN,  0, "s3_idle_run");
            expv(c + j, K_PLSO, 0, "s3_idle_plso");
        end

        step((c + 1) - cyc);
        start = 1'b1;
        step((c + 6) - cyc);
        start   = 1'b0;
        stop    = 1'b0;
        clr_req = 1'b0;

        step((c + 12) - cyc);
        start = 1'b1;
        stop  = 1'b1;
        s = c + 15;
        expv(s - 1, K_RUN,  0, "s4_run_pre");
        expv(s,     K_RUN,  1, "s4_run");
        expv(s,     K_PLSO, 1, "s4_plso");
        expv(s + 2, K_CNT,  0, "s4_cnt_pre");
        expv(s + 3, K_PLSO, 0, "s4_plso_fall");
        expv(s + 3, K_CNT,  1, "s4_cnt");
        step((s + 1) - cyc);
        start = 1'b0;
        stop  = 1'b0;

        step((c + 20) - cyc);
        clr_req = 1'b1;
        q = c + 20;
        expv(q + 3, K_RUN,  0, "s5_entry_run");
        expv(q + 3, K_CNT,  1, "s5_entry_cnt");
        step((q + 3) - cyc);
        clr_req = 1'b0;
        step((q + 5) - cyc);
        expv(q + 5, K_CLRO, 1, "s5_clro_before_rst");
        checks++;
        if (clro !== 1'b1) begin
            failures++;
            $display("FAIL s5_clro_direct cyc=%0d actual=%b required=1", cyc, clro);
        end
        rst = 1'b1;
        expv(q + 6, K_CLRO, 0, "s5_rst_clro");
        expv(q + 6, K_PLSO, 0, "s5_rst_plso");
        expv(q + 6, K_CNT,  0, "s5_rst_cnt");
        expv(q + 6, K_RUN,  0, "s5_rst_run");
        expv(q + 8, K_CLRO, 0, "s5_clro_stays_low");
        step(1);
        checks++;
        if (clro !== 1'b0 || plso !== 1'b0 || pls_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL s5_rst_direct cyc=%0d clro=%b plso=%b cnt=%h", cyc, clro, plso, pls_cnt);
        end
        rst = 1'b0;
        step(1);
        start = 1'b1;
        expv(q + 9,  K_RUN,  0, "s5_run_pre");
        expv(q + 10, K_RUN,  1, "s5_run");
        expv(q + 10, K_PLSO, 1, "s5_plso");
        expv(q + 13, K_PLSO, 0, "s5_plso_fall");
        expv(q + 13, K_CNT,  1, "s5_cnt");

        step((q + 14) - cyc);
        force dut.pls_cnt = 16'hFFFF;
        step(1);
        release dut.pls_cnt;
        expv(q + 15, K_CNT,  16'hFFFF, "s6_preload");
        expv(q + 22, K_CNT,  16'hFFFF, "s6_hold_high");
        expv(q + 22, K_PLSO, 1, "s6_plso_high");
        expv(q + 23, K_PLSO, 0, "s6_plso_fall");
        expv(q + 23, K_CNT,  16'h0000, "s6_wrap");
        expv(q + 33, K_CNT,  16'h0001, "s6_after_wrap");

        step((q + 40) - cyc);
        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL %s cyc=%0d actual=none required=%h", sb[i].nm, sb[i].cyc, sb[i].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
